prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the program ROM's edit/send write port.
- Accepts a byte stream from the host link (UART RX or similar), validates a framed program image, and packs each group of 4 bytes into a 32-bit code word.
- Issues one single-cycle send per word, with the matching line index, into the ROM.
- Reports completion or a coded error back to the host side.

Parameters:
- MAX_LINES, 64, maximum accepted line count; 64 lines × 4 bytes fills the 256-byte ROM.
- TIMEOUT_CYCLES, 50000, consecutive cycles without an accepted byte that abort a load in progress.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  cancel the load in progress
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  byte accepted on the cycle where in_valid & in_ready
- edit  out  1  ROM programming mode
- line  out  8  ROM line index
- code  out  32  ROM code word; byte0 in [7:0], byte3 in [31:24]
- send  out  1  ROM write strobe, one cycle per word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on a successful load
- error  out  1  sticky until the next accepted start
- err_code  out  3  0 none, 1 bad length, 2 timeout, 3 checksum, 4 abort
- lines_loaded  out  8  count of send pulses issued in the current load

Behaviour:
- Reset is asynchronous and active-high (rst); the clock is clk. While rst is high, all outputs are 0 and the state is IDLE.
- Frame format: LEN byte N, then 4·N payload bytes (little-endian per word), then CSUM byte. CSUM must equal the XOR of LEN and all payload bytes.
- States: IDLE, LEN, DATA, SEND, CSUM, DONE.
- IDLE:
  - in_ready=0, edit=0.
  - start → LEN next cycle. On that transition: clear error, err_code, lines_loaded, line; set edit=1.
- LEN:
  - in_ready=1.
  - On accept: if N==0 or N>MAX_LINES, take the error exit with code 1.
  - Otherwise store N, seed the XOR accumulator with N, clear the byte index, go to DATA.
- DATA:
  - in_ready=1.
  - Each accepted byte is written into code lane [byte_idx] and XORed into the accumulator; byte_idx increments.
  - Accepting byte_idx==3 → SEND.
- SEND (exactly one cycle):
  - in_ready=0, send=1.
  - line holds the current line index; code holds the completed word.
  - Next cycle: send=0, lines_loaded+1, line+1.
  - Go to CSUM if the incremented count equals N, else DATA.
- CSUM:
  - in_ready=1.
  - On accept, byte == accumulator → DONE; mismatch → error exit with code 3.
  - ROM contents are already written on a mismatch; the host reloads.
- DONE (one cycle): done=1, edit=0, next state IDLE.
- Error exit: next cycle error=1, err_code set, edit=0, state IDLE. done never pulses.
- Timeout:
  - The counter clears on entry to LEN/DATA/CSUM and on every accepted byte.
  - It increments each cycle in those states without an accept. It does not count in SEND.
  - When the counter reaches TIMEOUT_CYCLES, take the error exit with code 2.
- abort in any busy state: error exit with code 4. A send already driven in the current cycle completes.
- Priority within a cycle: rst > abort > timeout > byte accept.
- start while busy is ignored. start in the same cycle as the DONE or error exit is ignored; the earliest new start is in IDLE.
- line and code hold their last values after a load ends; only send qualifies them.
- Reset mid-load clears all outputs immediately. No partial send is emitted. The ROM keeps any words already written.

Test Plan:
- Good load:
  - Stimulus: start; stream 02, 80 00 00 11, 84 11 20 14, CSUM 32.
  - Required: send with line=0, code=0x11000080; send with line=1, code=0x14201184; done pulse; error=0; lines_loaded=2; edit falls with done.
- Bad checksum: same frame with CSUM 33 → both sends occur; error=1, err_code=3; no done pulse.
- Bad length:
  - LEN 00 → error=1, err_code=1, zero sends, edit low.
  - Repeat with LEN 41 (65) → same response.
- Timeout: TIMEOUT_CYCLES=16; send LEN 01 plus 2 payload bytes, then in_valid=0 → 16 cycles after the last accept, error=1, err_code=2, edit=0, busy=0.
- Backpressure:
  - in_valid gapped every other cycle → in_ready=0 on every SEND cycle.
  - A byte held valid across SEND is accepted on the following cycle.
  - Code words are correct and bytes are neither dropped nor duplicated.
- Reset and abort:
  - rst pulsed mid-DATA → all outputs 0 asynchronously; a subsequent good load passes.
  - abort during CSUM → err_code=4, no done pulse.

Source files
------------

// File: rtl/prog_loader.sv
// Framed program-image loader: validates LEN/payload/CSUM from a byte stream and
// writes each packed 32-bit word into the program ROM's edit/send port.
module prog_loader #(
  parameter int MAX_LINES      = 64,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        edit,
  output logic [7:0]  line,
  output logic [31:0] code,
  output logic        send,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [7:0]  lines_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_SEND, S_CSUM, S_DONE
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;

  state_t            state_q;
  logic              edit_q, send_q, done_q, error_q;
  logic [2:0]        err_code_q;
  logic [7:0]        line_q, lines_q, n_q, acc_q;
  logic [31:0]       code_q;
  logic [1:0]        idx_q;
  logic [TO_W-1:0]   to_q;

  logic              counting, accept, to_hit, abort_hit, bad_len;
  logic [7:0]        lines_d;
  logic [TO_W-1:0]   to_d;
  logic [2:0]        exit_code;

  // The counter only runs in byte-accepting states; SEND never counts.
  assign counting  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign in_ready  = counting && !abort;
  assign accept    = in_valid && in_ready;
  assign to_hit    = counting && !accept && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
  assign bad_len   = (in_data == 8'd0) || (in_data > 8'(MAX_LINES));
  assign lines_d   = lines_q + 8'd1;
  assign to_d      = to_q + TO_W'(1);

  always_comb begin
    exit_code = ERR_NONE;
    if (abort_hit)
      exit_code = ERR_ABORT;
    else if (to_hit)
      exit_code = ERR_TIMEOUT;
    else if (accept && (state_q == S_LEN) && bad_len)
      exit_code = ERR_LEN;
    else if (accept && (state_q == S_CSUM) && (in_data != acc_q))
      exit_code = ERR_CSUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edit_q     <= 1'b0;
      send_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      line_q     <= 8'd0;
      lines_q    <= 8'd0;
      n_q        <= 8'd0;
      acc_q      <= 8'd0;
      code_q     <= 32'd0;
      idx_q      <= 2'd0;
      to_q       <= '0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      if (exit_code != ERR_NONE) begin
        state_q    <= S_IDLE;
        edit_q     <= 1'b0;
        error_q    <= 1'b1;
        err_code_q <= exit_code;
        // An abort landing on SEND still lets that word's strobe count.
        if (state_q == S_SEND) begin
          lines_q <= lines_d;
          line_q  <= line_q + 8'd1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_LEN;
              edit_q     <= 1'b1;
              error_q    <= 1'b0;
              err_code_q <= ERR_NONE;
              lines_q    <= 8'd0;
              line_q     <= 8'd0;
              to_q       <= '0;
            end
          end
          S_LEN: begin
            if (accept) begin
              n_q     <= in_data;
              acc_q   <= in_data;
              idx_q   <= 2'd0;
              to_q    <= '0;
              state_q <= S_DATA;
            end else begin
              to_q <= to_d;
            end
          end
          S_DATA: begin
            if (accept) begin
              code_q[{idx_q, 3'b000} +: 8] <= in_data;
              acc_q <= acc_q ^ in_data;
              idx_q <= idx_q + 2'd1;
              to_q  <= '0;
              if (idx_q == 2'd3) begin
                state_q <= S_SEND;
                send_q  <= 1'b1;
              end
            end else begin
              to_q <= to_d;
            end
          end
          S_SEND: begin
            lines_q <= lines_d;
            line_q  <= line_q + 8'd1;
            to_q    <= '0;
            state_q <= (lines_d == n_q) ? S_CSUM : S_DATA;
          end
          S_CSUM: begin
            if (accept) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              edit_q  <= 1'b0;
            end else begin
              to_q <= to_d;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign edit         = edit_q;
  assign line         = line_q;
  assign code         = code_q;
  assign send         = send_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign lines_loaded = lines_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good load, bad checksum/length, timeout,
// backpressure, asynchronous reset and abort, against hand-computed values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, edit, send, busy, done, error;
  logic [7:0]  line, lines_loaded;
  logic [31:0] code;
  logic [2:0]  err_code;

  prog_loader #(.MAX_LINES(64), .TIMEOUT_CYCLES(16), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .edit(edit), .line(line), .code(code), .send(send), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .lines_loaded(lines_loaded)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int ns = 0, ndone = 0, rdy_bad = 0, edit_bad = 0;
  int sb = 0, db = 0, wcyc = 0, held_wait = 0;
  logic [7:0]  sline [0:63];
  logic [31:0] scode [0:63];

  // Send/done monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (send) begin
      if (ns < 64) begin
        sline[ns] = line;
        scode[ns] = code;
      end
      ns = ns + 1;
      if (in_ready) rdy_bad = rdy_bad + 1;
    end
    if (done) begin
      ndone = ndone + 1;
      if (edit) edit_bad = edit_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    wcyc = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!acc && wcyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      wcyc++;
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_start();
    sb = ns;
    db = ndone;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] csum);
    push(8'h02);
    push(8'h80); push(8'h00); push(8'h00); push(8'h11);
    push(8'h84);
    held_wait = wcyc;
    push(8'h11); push(8'h20); push(8'h14);
    push(csum);
  endtask

  task automatic check_good_tail();
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_edit_fall", {31'd0, edit}, 32'd0);
    tick(1);
    chk("good_done_end", {31'd0, done}, 32'd0);
    chk("good_busy", {31'd0, busy}, 32'd0);
    chk("good_error", {31'd0, error}, 32'd0);
    chk("good_lines", {24'd0, lines_loaded}, 32'd2);
    chk("good_nsend", ns - sb, 32'd2);
    chk("good_line0", {24'd0, sline[sb]}, 32'd0);
    chk("good_code0", scode[sb], 32'h11000080);
    chk("good_line1", {24'd0, sline[sb+1]}, 32'd1);
    chk("good_code1", scode[sb+1], 32'h14201184);
    chk("good_ndone", ndone - db, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(2);
    chk("rst_ctrl", {26'd0, send, done, error, edit, busy, in_ready}, 32'd0);
    chk("rst_data", {8'd0, line, lines_loaded, 5'd0, err_code}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Good load, byte 84 held valid across the first SEND.
    do_start();
    chk("start_edit", {31'd0, edit}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    load_frame(8'h32);
    check_good_tail();
    chk("held_wait", held_wait, 32'd2);

    // Bad checksum.
    do_start();
    load_frame(8'h33);
    chk("csum_error", {31'd0, error}, 32'd1);
    chk("csum_code", {29'd0, err_code}, 32'd3);
    chk("csum_busy", {31'd0, busy}, 32'd0);
    chk("csum_edit", {31'd0, edit}, 32'd0);
    chk("csum_nsend", ns - sb, 32'd2);
    tick(1);
    chk("csum_ndone", ndone - db, 32'd0);

    // Bad length 0 and 65; start must clear the sticky error.
    do_start();
    chk("len0_err_clr", {31'd0, error}, 32'd0);
    push(8'h00);
    chk("len0_error", {31'd0, error}, 32'd1);
    chk("len0_code", {29'd0, err_code}, 32'd1);
    chk("len0_edit", {31'd0, edit}, 32'd0);
    chk("len0_nsend", ns - sb, 32'd0);
    tick(1);
    do_start();
    push(8'h41);
    chk("len65_error", {31'd0, error}, 32'd1);
    chk("len65_code", {29'd0, err_code}, 32'd1);
    chk("len65_edit", {31'd0, edit}, 32'd0);
    chk("len65_nsend", ns - sb, 32'd0);
    tick(1);

    // Length 64 is the largest legal value; abort it from DATA.
    do_start();
    push(8'h40);
    chk("len64_error", {31'd0, error}, 32'd0);
    chk("len64_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("len64_abort_code", {29'd0, err_code}, 32'd4);
    chk("len64_abort_busy", {31'd0, busy}, 32'd0);

    // Timeout: 16 idle cycles after the last accept.
    do_start();
    push(8'h01); push(8'haa); push(8'hbb);
    tick(15);
    chk("to_early_error", {31'd0, error}, 32'd0);
    chk("to_early_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("to_error", {31'd0, error}, 32'd1);
    chk("to_code", {29'd0, err_code}, 32'd2);
    chk("to_edit", {31'd0, edit}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // Backpressure: in_valid gapped every other cycle.
    do_start();
    begin
      logic [7:0] fr [0:8];
      fr = '{8'h02, 8'hde, 8'had, 8'hbe, 8'hef, 8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 9; i++) begin
        push(fr[i]);
        tick(1);
      end
    end
    push(8'h24);
    chk("gap_done", {31'd0, done}, 32'd1);
    tick(1);
    chk("gap_nsend", ns - sb, 32'd2);
    chk("gap_code0", scode[sb], 32'hefbeadde);
    chk("gap_code1", scode[sb+1], 32'h04030201);
    chk("gap_lines", {24'd0, lines_loaded}, 32'd2);
    chk("gap_error", {31'd0, error}, 32'd0);

    // Asynchronous reset mid-DATA, then a clean reload.
    do_start();
    push(8'h02); push(8'h80);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ctrl", {26'd0, send, done, error, edit, busy, in_ready}, 32'd0);
    chk("arst_code", code, 32'd0);
    chk("arst_line", {16'd0, line, lines_loaded}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    do_start();
    load_frame(8'h32);
    check_good_tail();

    // Abort while waiting for CSUM.
    do_start();
    push(8'h01); push(8'h5a); push(8'ha5); push(8'hc3); push(8'h3c);
    tick(1);
    chk("ab_ready_csum", {31'd0, in_ready}, 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_error", {31'd0, error}, 32'd1);
    chk("ab_code", {29'd0, err_code}, 32'd4);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_nsend", ns - sb, 32'd1);
    chk("ab_code_word", scode[sb], 32'h3cc3a55a);
    tick(2);
    chk("ab_ndone", ndone - db, 32'd0);

    chk("ready_in_send", rdy_bad, 32'd0);
    chk("edit_with_done", edit_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
